// File: rtl/lvt_port_scheduler_if.sv
//==============================================================================
// Module   : lvt_port_scheduler_if
// Brief    : Client request/response and memory-port bundle for the scheduler.
// Revision : 1.0
//==============================================================================
`default_nettype none

interface lvt_port_scheduler_if #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 512,
  parameter int PORTS      = 2,
  parameter int REQUESTERS = 4
);
  localparam int AW = $clog2(DEPTH);

  logic [REQUESTERS-1:0]       req_valid;
  logic [REQUESTERS-1:0]       req_we;
  logic [REQUESTERS*AW-1:0]    req_addr;
  logic [REQUESTERS*WIDTH-1:0] req_wdata;
  logic [REQUESTERS-1:0]       req_ready;
  logic [REQUESTERS-1:0]       rsp_valid;
  logic [REQUESTERS*WIDTH-1:0] rsp_rdata;
  logic [PORTS*AW-1:0]         mem_addr;
  logic [PORTS-1:0]            mem_en;
  logic [PORTS*WIDTH-1:0]      mem_d;
  logic [PORTS*WIDTH-1:0]      mem_q;

  // Client and memory side together.
  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_q,
    input  req_ready, rsp_valid, rsp_rdata, mem_addr, mem_en, mem_d
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mem_q,
    output req_ready, rsp_valid, rsp_rdata, mem_addr, mem_en, mem_d
  );
endinterface

`default_nettype wire

// File: rtl/lvt_port_scheduler.sv
//==============================================================================
// Module   : lvt_port_scheduler
// Brief    : Round-robin sharing of LVT memory ports among requesters, with
//            fixed-latency read-return tracking. Option: LVT_SCHED_PERF_EN.
// Revision : 1.0
//==============================================================================
`default_nettype none

module lvt_port_scheduler #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 512,
  parameter int PORTS      = 2,
  parameter int REQUESTERS = 4,
  parameter int LATENCY    = 4
) (
  input  wire logic clk,
  input  wire logic rst_n,
`ifdef LVT_SCHED_PERF_EN
  output logic [31:0] perf_grants,
  output logic [31:0] perf_stalls,
`endif
  lvt_port_scheduler_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int RW = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;

  logic [RW-1:0]                   r_rr_ptr;
  logic [REQUESTERS-1:0]           w_grant;
  logic [RW-1:0]                   w_rr_next;
  logic                            w_any;
  logic [PORTS-1:0]                w_pv;
  logic [PORTS-1:0]                w_pwe;
  logic [PORTS-1:0][AW-1:0]        w_paddr;
  logic [PORTS-1:0][WIDTH-1:0]     w_pd;
  logic [PORTS-1:0][RW-1:0]        w_pid;

  logic [PORTS*AW-1:0]             r_mem_addr;
  logic [PORTS-1:0]                r_mem_en;
  logic [PORTS*WIDTH-1:0]          r_mem_d;
  logic [LATENCY:0][PORTS-1:0]     r_trk_vld;
  logic [LATENCY:0][PORTS-1:0][RW-1:0] r_trk_id;
  logic [REQUESTERS-1:0]           r_rsp_valid;
  logic [REQUESTERS*WIDTH-1:0]     r_rsp_rdata;

  always_comb begin : p_arb
    int  idx;
    int  cnt;
    logic hit;
    w_grant   = '0;
    w_any     = 1'b0;
    w_rr_next = r_rr_ptr;
    w_pv      = '0;
    w_pwe     = '0;
    w_paddr   = '0;
    w_pd      = '0;
    w_pid     = '0;
    idx       = 0;
    cnt       = 0;
    hit       = 1'b0;
    if (rst_n) begin
      for (int i = 0; i < REQUESTERS; i++) begin
        idx = (int'(r_rr_ptr) + i) % REQUESTERS;
        // A write may not share an address with a write already placed this cycle.
        hit = 1'b0;
        for (int k = 0; k < PORTS; k++) begin
          if (k < cnt && w_pwe[k] && bus.req_we[idx] &&
              w_paddr[k] == bus.req_addr[idx*AW +: AW]) begin
            hit = 1'b1;
          end
        end
        if (cnt < PORTS && bus.req_valid[idx] && !hit) begin
          w_grant[idx] = 1'b1;
          w_pv[cnt]    = 1'b1;
          w_pwe[cnt]   = bus.req_we[idx];
          w_paddr[cnt] = bus.req_addr[idx*AW +: AW];
          w_pd[cnt]    = bus.req_we[idx] ? bus.req_wdata[idx*WIDTH +: WIDTH] : '0;
          w_pid[cnt]   = RW'(idx);
          w_rr_next    = RW'((idx + 1) % REQUESTERS);
          w_any        = 1'b1;
          cnt          = cnt + 1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr    <= '0;
      r_mem_addr  <= '0;
      r_mem_en    <= '0;
      r_mem_d     <= '0;
      r_trk_vld   <= '0;
      r_trk_id    <= '0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
    end else begin
      if (w_any) begin
        r_rr_ptr <= w_rr_next;
      end
      for (int p = 0; p < PORTS; p++) begin
        r_mem_en[p]                  <= w_pv[p] & w_pwe[p];
        r_mem_addr[p*AW +: AW]       <= w_paddr[p];
        r_mem_d[p*WIDTH +: WIDTH]    <= w_pd[p];
        r_trk_vld[0][p]              <= w_pv[p] & ~w_pwe[p];
        r_trk_id[0][p]               <= w_pid[p];
      end
      for (int s = 1; s <= LATENCY; s++) begin
        r_trk_vld[s] <= r_trk_vld[s-1];
        r_trk_id[s]  <= r_trk_id[s-1];
      end
      // Requester ids are unique across ports in one slot, so no write conflict.
      r_rsp_valid <= '0;
      for (int p = 0; p < PORTS; p++) begin
        if (r_trk_vld[LATENCY][p]) begin
          r_rsp_valid[r_trk_id[LATENCY][p]] <= 1'b1;
          r_rsp_rdata[r_trk_id[LATENCY][p]*WIDTH +: WIDTH] <= bus.mem_q[p*WIDTH +: WIDTH];
        end
      end
    end
  end

  assign bus.req_ready = w_grant;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_en    = r_mem_en;
  assign bus.mem_d     = r_mem_d;

`ifdef LVT_SCHED_PERF_EN
  logic [31:0] r_perf_grants;
  logic [31:0] r_perf_stalls;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_grants <= '0;
      r_perf_stalls <= '0;
    end else begin
      r_perf_grants <= r_perf_grants + 32'($countones(w_grant));
      if (|(bus.req_valid & ~w_grant)) begin
        r_perf_stalls <= r_perf_stalls + 32'd1;
      end
    end
  end

  assign perf_grants = r_perf_grants;
  assign perf_stalls = r_perf_stalls;
`else
  // Performance counters compiled out.
`endif

endmodule

`default_nettype wire

// File: tb/tb_lvt_port_scheduler.sv
//==============================================================================
// Module   : tb_lvt_port_scheduler
// Brief    : Self-checking bench: vector table, directed corner cases and
//            randomized traffic against a reference scheduler/memory model.
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_lvt_port_scheduler;
  localparam int W     = 32;
  localparam int DEPTH = 512;
  localparam int P     = 2;
  localparam int R     = 4;
  localparam int L     = 4;
  localparam int AW    = $clog2(DEPTH);

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  lvt_port_scheduler_if #(.WIDTH(W), .DEPTH(DEPTH), .PORTS(P), .REQUESTERS(R)) bus ();

`ifdef LVT_SCHED_PERF_EN
  logic [31:0] perf_grants;
  logic [31:0] perf_stalls;
`endif

  lvt_port_scheduler #(.WIDTH(W), .DEPTH(DEPTH), .PORTS(P), .REQUESTERS(R), .LATENCY(L)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef LVT_SCHED_PERF_EN
    .perf_grants(perf_grants),
    .perf_stalls(perf_stalls),
`endif
    .bus        (bus)
  );

  // Memory: reads return pre-write contents when a write lands on the same edge.
  logic [W-1:0] mem   [DEPTH];
  logic [W-1:0] qpipe [L][P];

  always @(posedge clk) begin
    for (int p = 0; p < P; p++) begin
      qpipe[0][p] <= mem[bus.mem_addr[p*AW +: AW]];
      for (int s = 1; s < L; s++) qpipe[s][p] <= qpipe[s-1][p];
    end
    for (int p = 0; p < P; p++)
      if (bus.mem_en[p]) mem[bus.mem_addr[p*AW +: AW]] = bus.mem_d[p*W +: W];
  end

  for (genvar p = 0; p < P; p++) begin : g_q
    assign bus.mem_q[p*W +: W] = qpipe[L-1][p];
  end

  // Reference state
  typedef struct { int due; int r; logic [W-1:0] d; } exp_t;
  exp_t         eq[$];
  logic [W-1:0] ref_mem [DEPTH];
  int           rr;
  int           cyc;
  int           last_rsp_cyc [R];
  logic [W-1:0] last_rsp_data[R];
  int           rsp_cnt      [R];
  logic [R-1:0] last_rdy;
  int           ref_grants;
  int           ref_stalls;
  int           n_checks = 0;
  int           n_pass   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [R*AW-1:0] pk(input int a0, input int a1, input int a2, input int a3);
    return {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
  endfunction

  function automatic logic [R*W-1:0] dk(input logic [W-1:0] d0, input logic [W-1:0] d1,
                                        input logic [W-1:0] d2, input logic [W-1:0] d3);
    return {d3, d2, d1, d0};
  endfunction

  // One clock cycle: drive, compare grants with the model, advance, compare outputs.
  task automatic cycle(input logic [R-1:0] v, input logic [R-1:0] we,
                       input logic [R*AW-1:0] a, input logic [R*W-1:0] d);
    logic [R-1:0]      g;
    logic [P-1:0]      en;
    logic [P*AW-1:0]   ma;
    logic [P*W-1:0]    md;
    logic [R-1:0]      ev;
    logic [R*W-1:0]    ed;
    int                last, k, r;
    bit                blk;
    bus.req_valid = v;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = d;
    #1;
    g = '0; en = '0; ma = '0; md = '0; last = rr; k = 0;
    for (int i = 0; i < R; i++) begin
      r   = (rr + i) % R;
      blk = 1'b0;
      for (int j = 0; j < R; j++)
        if (g[j] && we[j] && we[r] && a[j*AW +: AW] == a[r*AW +: AW]) blk = 1'b1;
      if (v[r] && k < P && !blk) begin
        g[r] = 1'b1;
        last = r;
        ma[k*AW +: AW] = a[r*AW +: AW];
        if (we[r]) begin
          en[k] = 1'b1;
          md[k*W +: W] = d[r*W +: W];
        end
        k++;
      end
    end
    chk("req_ready", bus.req_ready, g);
    last_rdy = bus.req_ready;
    for (int i = 0; i < R; i++)
      if (g[i] && !we[i]) eq.push_back('{cyc + L + 2, i, ref_mem[a[i*AW +: AW]]});
    for (int i = 0; i < R; i++)
      if (g[i] && we[i]) ref_mem[a[i*AW +: AW]] = d[i*W +: W];
    if (g != '0) rr = (last + 1) % R;
    ref_grants += $countones(g);
    if ((v & ~g) != '0) ref_stalls++;
    @(posedge clk);
    cyc++;
    #1;
    chk("mem_en", bus.mem_en, en);
    chk("mem_addr", bus.mem_addr, ma);
    chk("mem_d", bus.mem_d, md);
    ev = '0; ed = '0;
    for (int i = eq.size() - 1; i >= 0; i--)
      if (eq[i].due == cyc) begin
        ev[eq[i].r] = 1'b1;
        ed[eq[i].r*W +: W] = eq[i].d;
        eq.delete(i);
      end
    chk("rsp_valid", bus.rsp_valid, ev);
    for (int i = 0; i < R; i++) begin
      if (ev[i]) chk("rsp_rdata", bus.rsp_rdata[i*W +: W], ed[i*W +: W]);
      if (bus.rsp_valid[i]) begin
        last_rsp_cyc[i]  = cyc;
        last_rsp_data[i] = bus.rsp_rdata[i*W +: W];
        rsp_cnt[i]++;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle('0, '0, '0, '0);
  endtask

  task automatic do_reset(input logic [R-1:0] v);
    bus.req_valid = v;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    rst_n = 1'b0;
    #1;
    chk("rst_ctl", {bus.req_ready, bus.rsp_valid, bus.mem_en}, '0);
    chk("rst_rdata", bus.rsp_rdata, '0);
    chk("rst_mem_bus", {bus.mem_addr, bus.mem_d}, '0);
    @(posedge clk);
    #1;
    chk("rst_hold", {bus.req_ready, bus.rsp_valid, bus.mem_en}, '0);
    bus.req_valid = '0;
    rst_n = 1'b1;
    rr = 0; cyc = 0; ref_grants = 0; ref_stalls = 0;
    eq.delete();
    for (int i = 0; i < R; i++) begin
      last_rsp_cyc[i] = -1;
      last_rsp_data[i] = '0;
      rsp_cnt[i] = 0;
    end
  endtask

  typedef struct {
    logic [R-1:0]    v;
    logic [R-1:0]    we;
    logic [R*AW-1:0] a;
    logic [R-1:0]    rdy;
  } vec_t;
  vec_t tbl [11];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int hs;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = 32'hC0DE_0000 | i;
      ref_mem[i] = 32'hC0DE_0000 | i;
    end
    mem[5]     = 32'h0000_00A5;
    ref_mem[5] = 32'h0000_00A5;

    tbl[0]  = '{4'b1111, 4'b0000, pk(1, 2, 3, 4),     4'b0011};
    tbl[1]  = '{4'b1111, 4'b0000, pk(5, 6, 7, 8),     4'b1100};
    tbl[2]  = '{4'b0100, 4'b0000, pk(0, 0, 20, 0),    4'b0100};
    tbl[3]  = '{4'b1001, 4'b0000, pk(21, 0, 0, 22),   4'b1001};
    tbl[4]  = '{4'b0000, 4'b0000, pk(0, 0, 0, 0),     4'b0000};
    tbl[5]  = '{4'b0001, 4'b0000, pk(23, 0, 0, 0),    4'b0001};
    tbl[6]  = '{4'b0110, 4'b0110, pk(0, 9, 9, 0),     4'b0010};
    tbl[7]  = '{4'b0100, 4'b0100, pk(0, 0, 9, 0),     4'b0100};
    tbl[8]  = '{4'b1110, 4'b1010, pk(0, 7, 7, 7),     4'b1100};
    tbl[9]  = '{4'b1111, 4'b1111, pk(10, 11, 12, 13), 4'b1001};
    tbl[10] = '{4'b1111, 4'b0000, pk(10, 11, 12, 13), 4'b0110};

    #2;
    do_reset('0);

    // Single read: ready at once, data LATENCY+2 cycles later.
    hs = cyc;
    cycle(4'b0001, 4'b0000, pk(5, 0, 0, 0), '0);
    chk("A_ready", last_rdy, 4'b0001);
    for (int i = 0; i < 20 && last_rsp_cyc[0] < 0; i++) idle(1);
    chk("A_latency", last_rsp_cyc[0] - hs, L + 2);
    chk("A_data", last_rsp_data[0], 32'h0000_00A5);

    do_reset('0);
    for (int i = 0; i < 11; i++) begin
      cycle(tbl[i].v, tbl[i].we, tbl[i].a,
            dk({8'hD0, 8'(i), 16'd0}, {8'hD0, 8'(i), 16'd1}, {8'hD0, 8'(i), 16'd2}, {8'hD0, 8'(i), 16'd3}));
      chk("tbl_ready", last_rdy, tbl[i].rdy);
    end
    idle(L + 3);

    // Write collision on address 9.
    do_reset('0);
    cycle(4'b0110, 4'b0110, pk(0, 9, 9, 0), dk('0, 32'h1111_0001, 32'h2222_0002, '0));
    chk("C_first", last_rdy, 4'b0010);
    cycle(4'b0100, 4'b0100, pk(0, 0, 9, 0), dk('0, '0, 32'h2222_0002, '0));
    chk("C_second", last_rdy, 4'b0100);
    idle(3);
    chk("C_mem9", mem[9], 32'h2222_0002);

    // Write then read the same address one cycle later.
    do_reset('0);
    cycle(4'b0001, 4'b0001, pk(3, 0, 0, 0), dk(32'h0000_1234, '0, '0, '0));
    chk("D_wr_ready", last_rdy, 4'b0001);
    cycle(4'b0001, 4'b0000, pk(3, 0, 0, 0), '0);
    chk("D_rd_ready", last_rdy, 4'b0001);
    idle(L + 3);
    chk("D_data", last_rsp_data[0], 32'h0000_1234);

    // Continuous reads from every requester.
    do_reset('0);
    for (int i = 0; i < 8; i++) begin
      cycle(4'b1111, 4'b0000, pk(i, i + 1, i + 2, i + 3), '0);
      chk("B_ready", last_rdy, (i % 2 == 0) ? 4'b0011 : 4'b1100);
    end
    idle(L + 3);
    for (int i = 0; i < R; i++) chk("B_rsp_count", rsp_cnt[i], 4);

    // Reset while three reads are in flight; requests held during reset.
    cycle(4'b0111, 4'b0000, pk(1, 2, 3, 0), '0);
    cycle(4'b0100, 4'b0000, pk(0, 0, 4, 0), '0);
    do_reset(4'b1111);
    idle(L + 4);
    chk("E_no_rsp", rsp_cnt[0] + rsp_cnt[1] + rsp_cnt[2] + rsp_cnt[3], 0);

    // Randomized traffic over a small address range to provoke collisions.
    for (int n = 0; n < 400; n++) begin
      cycle(R'($urandom), R'($urandom),
            pk($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15)),
            dk($urandom, $urandom, $urandom, $urandom));
    end
    idle(L + 3);
    chk("drain", eq.size(), 0);
`ifdef LVT_SCHED_PERF_EN
    chk("perf_grants", perf_grants, 32'(ref_grants));
    chk("perf_stalls", perf_stalls, 32'(ref_stalls));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
